// File: rtl/ps2_key_mapper_pkg.sv
// Shared types and constants for the PS/2 key mapper.
package ps2_pkg;

  // Prefix bytes that modify the meaning of the following scan code
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Receiver frame position
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // {extended flag, scan code}
  typedef logic [8:0] key_code_t;

endpackage

// File: rtl/ps2_key_mapper_if.sv
// PS/2 pins plus the decoded per-key outputs of the key mapper.
interface ps2_key_mapper_if #(
  parameter int NUM_KEYS = 4
);
  logic                ps2_clk;
  logic                ps2_data;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                frame_err;

  // Environment side: drives the pins, consumes the key state
  modport master (
    output ps2_clk, ps2_data,
    input  key_held, key_press, key_release, frame_err
  );

  // Mapper side
  modport slave (
    input  ps2_clk, ps2_data,
    output key_held, key_press, key_release, frame_err
  );
endinterface

// File: rtl/ps2_key_mapper_rx.sv
// PS/2 frame receiver: synchronisers, clock glitch filter, frame FSM and
// inactivity timeout. Emits one registered byte_valid or frame_err pulse
// the cycle after the stop-bit strobe.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Odd parity: data bits plus parity bit must contain an odd number of ones
  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          strobe;
  logic          strobe_data;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;

  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filtered clock follows only after FILTER_LEN consecutive differing
  // samples; a transition to 0 produces the one-cycle bit strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 1'b1;
      fcnt   <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_sync[1] != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt   <= clk_sync[1];
          fcnt   <= '0;
          strobe <= ~clk_sync[1];
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Data bit captured in the same cycle the strobe is generated
  always_ff @(posedge clk) begin
    strobe_data <= data_sync[1];
  end

  // Frame FSM with timeout; a strobe always takes priority over the timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!strobe_data) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {strobe_data, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= strobe_data;
            state <= STOP;
          end
          STOP: begin
            if (strobe_data && parity_ok(shreg, par)) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_mapper.sv
// PS/2 key mapper top: tracks E0/F0 prefixes and maps received scan codes
// onto per-channel held levels and press/release pulses.
module ps2_key_mapper
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h174, 9'h16B, 9'h029, 9'h02D},
  parameter int                    FILTER_LEN     = 8,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  ps2_key_mapper_if.slave   bus
);

  logic [7:0]          rx_byte;
  logic                byte_valid;
  logic                rx_err;
  logic                ext;
  logic                brk;
  key_code_t           rx_code;
  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_q;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_err)
  );

  assign rx_code = {ext, rx_byte};

  // One comparator per channel; duplicate codes simply match together
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cmp
    assign match[i] = (KEY_CODES[9*i +: 9] == rx_code);
  end

  // Prefix tracking and per-key state; pulses only on actual level changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      held      <= '0;
      press     <= '0;
      release_q <= '0;
    end else begin
      press     <= '0;
      release_q <= '0;
      if (rx_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (rx_byte == PS2_PREFIX_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          brk <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (match[i]) begin
              if (!brk) begin
                held[i]  <= 1'b1;
                press[i] <= ~held[i];
              end else begin
                held[i]      <= 1'b0;
                release_q[i] <= held[i];
              end
            end
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign bus.key_held    = held;
  assign bus.key_press   = press;
  assign bus.key_release = release_q;
  assign bus.frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_mapper.sv
// Directed bench for ps2_key_mapper: sends PS/2 frames bit by bit and checks
// held levels and pulse counts against hand-computed values.
module tb_ps2_key_mapper;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  int press_cnt [4];
  int rel_cnt   [4];
  int err_cnt;
  int err_long;
  int overlap;

  ps2_key_mapper_if #(.NUM_KEYS(4)) bus ();

  ps2_key_mapper #(
    .NUM_KEYS       (4),
    .KEY_CODES      ({9'h174, 9'h16B, 9'h029, 9'h02D}),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  logic err_prev = 1'b0;
  initial begin
    err_cnt  = 0;
    err_long = 0;
    overlap  = 0;
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.key_press[i])   press_cnt[i] = press_cnt[i] + 1;
      if (bus.key_release[i]) rel_cnt[i]   = rel_cnt[i] + 1;
    end
    if ((bus.key_press & bus.key_release) != 4'b0) overlap = overlap + 1;
    if (bus.frame_err) err_cnt = err_cnt + 1;
    if (bus.frame_err && err_prev) err_long = err_long + 1;
    err_prev = bus.frame_err;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Shift out the low n bits of a frame, LSB first, data set while clock high
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      wait_cycles(HALF);
      bus.ps2_clk = 1'b0;
      wait_cycles(HALF);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_parity);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    send_bits(frame, 11);
    bus.ps2_data = 1'b1;
    wait_cycles(60);
  endtask

  task automatic chk_held(input string tag, input logic [3:0] exp);
    @(negedge clk);
    check(tag, 32'(bus.key_held), 32'(exp));
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    check("reset_held",    32'(bus.key_held),    0);
    check("reset_press",   32'(bus.key_press),   0);
    check("reset_release", 32'(bus.key_release), 0);
    check("reset_err",     32'(bus.frame_err),   0);
    rst_n = 1'b1;
    wait_cycles(20);

    // Space make then break
    send_byte(8'h29, 1'b0);
    chk_held("space_make_held", 4'b0010);
    check("space_make_press", press_cnt[1], 1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    chk_held("space_break_held", 4'b0000);
    check("space_break_rel", rel_cnt[1], 1);

    // Extended left arrow vs keypad 4
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    chk_held("left_make_held", 4'b0100);
    check("left_make_press", press_cnt[2], 1);
    send_byte(8'h6B, 1'b0);
    chk_held("kp4_no_change", 4'b0100);
    check("kp4_no_press", press_cnt[2], 1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    chk_held("left_break_held", 4'b0000);
    check("left_break_rel", rel_cnt[2], 1);

    // Typematic repeat gives one press
    repeat (3) send_byte(8'h29, 1'b0);
    chk_held("repeat_held", 4'b0010);
    check("repeat_press", press_cnt[1], 2);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    chk_held("repeat_break_held", 4'b0000);
    check("repeat_break_rel", rel_cnt[1], 2);

    // Bad parity then good frame
    send_byte(8'h2D, 1'b1);
    chk_held("parity_held", 4'b0000);
    check("parity_err", err_cnt, 1);
    send_byte(8'h2D, 1'b0);
    chk_held("r_make_held", 4'b0001);
    check("r_make_press", press_cnt[0], 1);

    // Timeout on a truncated frame: start + 4 data bits
    send_bits(11'b000_0000_0100, 5);
    bus.ps2_data = 1'b1;
    wait_cycles(TIMEOUT + 100);
    check("timeout_err", err_cnt, 2);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    chk_held("right_make_held", 4'b1001);
    check("right_make_press", press_cnt[3], 1);

    // Short clock glitch with data low must not start a frame
    bus.ps2_data = 1'b0;
    wait_cycles(3);
    bus.ps2_clk = 1'b0;
    wait_cycles(4);
    bus.ps2_clk = 1'b1;
    wait_cycles(3);
    bus.ps2_data = 1'b1;
    wait_cycles(40);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h2D, 1'b0);
    chk_held("glitch_r_break_held", 4'b1000);
    check("glitch_r_rel", rel_cnt[0], 1);
    check("glitch_no_err", err_cnt, 2);

    // Reset in the middle of a frame with key 3 held
    send_bits(11'b000_0001_0110, 5);
    rst_n = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    check("midrst_held",    32'(bus.key_held),    0);
    check("midrst_press",   32'(bus.key_press),   0);
    check("midrst_release", 32'(bus.key_release), 0);
    bus.ps2_data = 1'b1;
    bus.ps2_clk  = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(TIMEOUT + 100);
    check("midrst_no_err", err_cnt, 2);
    check("midrst_no_rel", rel_cnt[3], 0);
    send_byte(8'h29, 1'b0);
    chk_held("post_rst_held", 4'b0010);

    check("err_one_cycle", err_long, 0);
    check("press_rel_exclusive", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
